seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 170 +++++++++++++++++
 tb/tb_seq_div.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// rtl/seq_div.sv - iterative signed 32-bit restoring divider, hi=remainder lo=quotient
// Optional macro SEQ_DIV_ZERO_TRAP_EN: b=0 completes in one edge with div_zero set.
module seq_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic        r_qsign;
  logic        r_rsign;
  logic        r_done;

  logic        w_load;
  logic        w_step;
  logic        w_fix;
  logic        w_zero_hit;
  logic        w_trap;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_lo_fix;
  logic [31:0] w_hi_fix;

  // |0x80000000| wraps to itself, which is the correct unsigned magnitude
  assign w_abs_a = a[31] ? (~a + 32'd1) : a;
  assign w_abs_b = b[31] ? (~b + 32'd1) : b;

`ifdef SEQ_DIV_ZERO_TRAP_EN
  assign w_trap = (b == 32'd0);
`else
  assign w_trap = 1'b0;
`endif

  // Partial remainder stays below the divisor, so the 33-bit shifted value
  // minus the divisor always fits in 32 bits whenever the trial succeeds.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_ge       = (w_shift >= {1'b0, r_dvsr});
  assign w_sub      = w_shift[31:0] - r_dvsr;
  assign w_rem_next = w_ge ? w_sub : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_ge};

  assign w_lo_fix = r_qsign ? (~r_quo + 32'd1) : r_quo;
  assign w_hi_fix = r_rsign ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    w_zero_hit   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (div_start) begin
          if (w_trap) begin
            w_zero_hit = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == 6'd1) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        busy         = 1'b1;
        w_fix        = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvsr  <= 32'd0;
      r_cnt   <= 6'd0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_fix | w_zero_hit;
      if (w_load) begin
        r_rem   <= 32'd0;
        r_quo   <= w_abs_a;
        r_dvsr  <= w_abs_b;
        r_qsign <= a[31] ^ b[31];
        r_rsign <= a[31];
        r_cnt   <= 6'd32;
      end else if (w_step) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt - 6'd1;
      end
      if (w_fix) begin
        r_lo <= w_lo_fix;
        r_hi <= w_hi_fix;
      end
    end
  end

`ifdef SEQ_DIV_ZERO_TRAP_EN
  logic r_div_zero;

  // Sticky until the next start that actually launches a division
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_zero <= 1'b0;
    end else if (w_zero_hit) begin
      r_div_zero <= 1'b1;
    end else if (w_load) begin
      r_div_zero <= 1'b0;
    end
  end

  assign div_zero = r_div_zero;
`else
  assign div_zero = 1'b0;
`endif

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed self-checking bench for seq_div
// Build with SEQ_DIV_ZERO_TRAP_EN defined to exercise the divide-by-zero trap.
module tb_seq_div;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_checks;
  int n_fail;

  seq_div dut (
    .clk      (clk),
    .reset    (reset),
    .div_start(div_start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and wait (bounded) for done; lat is edges after the accepting edge.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output int lat, output int busy_cnt, output bit held);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi;
    l0 = lo;
    held = 1'b1;
    a = ia;
    b = ib;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    lat = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    if (hi !== h0 || lo !== l0) held = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b1 && (hi !== h0 || lo !== l0)) held = 1'b0;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    div_start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
  endtask

  task automatic test_basic();
    int lat;
    int bc;
    bit held;
    run_op(32'd100, 32'd7, lat, bc, held);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL basic_latency: got %0d expected 33", lat); end
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 33", bc); end
    n_checks++; if (!held) begin n_fail++; $display("FAIL basic_hold: hi/lo changed before done, expected held"); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL basic_lo: got %h expected %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL basic_hi: got %h expected %h", hi, 32'd2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL basic_lo_kept: got %h expected %h", lo, 32'd14); end
  endtask

  task automatic test_signs();
    int lat;
    int bc;
    bit held;
    run_op(32'hFFFF_FF9C, 32'd7, lat, bc, held);
    n_checks++; if (lo !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL neg_a_lo: got %h expected %h", lo, 32'hFFFF_FFF2); end
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg_a_hi: got %h expected %h", hi, 32'hFFFF_FFFE); end
    run_op(32'd100, 32'hFFFF_FFF9, lat, bc, held);
    n_checks++; if (lo !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL neg_b_lo: got %h expected %h", lo, 32'hFFFF_FFF2); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL neg_b_hi: got %h expected %h", hi, 32'd2); end
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bc, held);
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL neg_both_lo: got %h expected %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg_both_hi: got %h expected %h", hi, 32'hFFFF_FFFE); end
  endtask

  task automatic test_boundary();
    int lat;
    int bc;
    bit held;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bc, held);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo: got %h expected %h", lo, 32'h8000_0000); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ovf_hi: got %h expected %h", hi, 32'd0); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL ovf_flag: got %b expected 0", div_zero); end
    run_op(32'd5, 32'd9, lat, bc, held);
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL small_lo: got %h expected %h", lo, 32'd0); end
    n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL small_hi: got %h expected %h", hi, 32'd5); end
    run_op(32'd0, 32'd3, lat, bc, held);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL zero_a_latency: got %0d expected 33", lat); end
    n_checks++; if (lo !== 32'd0 || hi !== 32'd0) begin n_fail++; $display("FAIL zero_a_result: got lo=%h hi=%h expected 0/0", lo, hi); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    bit held;
    a = 32'd100;
    b = 32'd7;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a = 32'd1000;
    b = 32'd3;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    lat = 5;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL ignore_lo: got %h expected %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL ignore_hi: got %h expected %h", hi, 32'd2); end
    run_op(32'd77, 32'hFFFF_FFFB, lat, bc, held);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL b2b_lo: got %h expected %h", lo, 32'hFFFF_FFF1); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi: got %h expected %h", hi, 32'd2); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int bc;
    bit held;
    bit saw_done;
    a = 32'd50;
    b = 32'd5;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_result: got lo=%h hi=%h expected 0/0", lo, hi); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got done pulse expected none"); end
    run_op(32'd50, 32'd5, lat, bc, held);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d expected 33", lat); end
    n_checks++; if (lo !== 32'd10) begin n_fail++; $display("FAIL abort_rerun_lo: got %h expected %h", lo, 32'd10); end
  endtask

  task automatic test_div_zero();
    int lat;
    int bc;
    bit held;
`ifdef SEQ_DIV_ZERO_TRAP_EN
    a = 32'd9;
    b = 32'd0;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dz_done: got %b expected 1", done); end
    n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy: got %b expected 0", busy); end
    n_checks++; if (lo !== 32'd10 || hi !== 32'd0) begin n_fail++; $display("FAIL dz_unchanged: got lo=%h hi=%h expected 0000000a/00000000", lo, hi); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dz_done_pulse: got %b expected 0", done); end
    n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_sticky: got %b expected 1", div_zero); end
    run_op(32'd10, 32'd3, lat, bc, held);
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_cleared: got %b expected 0", div_zero); end
    n_checks++; if (lo !== 32'd3 || hi !== 32'd1) begin n_fail++; $display("FAIL dz_next_op: got lo=%h hi=%h expected 3/1", lo, hi); end
`else
    run_op(32'd9, 32'd0, lat, bc, held);
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL dz_latency: got %0d expected 33", lat); end
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
    n_checks++; if (hi !== 32'd9) begin n_fail++; $display("FAIL dz_hi: got %h expected %h", hi, 32'd9); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag: got %b expected 0", div_zero); end
    run_op(32'hFFFF_FFF7, 32'd0, lat, bc, held);
    n_checks++; if (lo !== 32'd1) begin n_fail++; $display("FAIL dz_neg_lo: got %h expected %h", lo, 32'd1); end
    n_checks++; if (hi !== 32'hFFFF_FFF7) begin n_fail++; $display("FAIL dz_neg_hi: got %h expected %h", hi, 32'hFFFF_FFF7); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    div_start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    test_reset();
    test_basic();
    test_signs();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    test_div_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
